// File: rtl/d0_load_unit.sv
// Single-byte load unit: req/ack read from data memory, then a one-cycle write
// into an 8-bit data register, with a timeout abort for a silent memory.
module d0_load_unit #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata
);

  localparam int unsigned    TimerW   = $clog2(TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWrite, StErr} state_e;

  state_e            state;
  logic [TimerW-1:0] timer;

  // mem_addr doubles as the latched address; reg_wdata doubles as the captured byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      timer     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      reg_we    <= 1'b0;
      reg_wdata <= '0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      reg_we <= 1'b0;
      case (state)
        StIdle: begin
          if (ld_start) begin
            state    <= StReq;
            mem_addr <= ld_addr;
            mem_req  <= 1'b1;
            busy     <= 1'b1;
            timer    <= '0;
          end
        end
        StReq: begin
          // An ack in the last allowed cycle still completes the load.
          if (mem_ack) begin
            reg_wdata <= mem_rdata;
            mem_req   <= 1'b0;
            reg_we    <= 1'b1;
            done      <= 1'b1;
            state     <= StWrite;
          end else if (timer == TimerLast) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= StErr;
          end else begin
            timer <= timer + TimerW'(1);
          end
        end
        StWrite, StErr: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          state   <= StIdle;
        end
      endcase
    end
  end

endmodule
